pline_flush_unit: RTL and testbench

//   Parametrised pipeline flush controller. Per-stage ignore (bubble) vector for an
//   N-stage in-order pipeline. Two flush sources: branch mispredict and exception,

---
 rtl/pline_flush_unit.sv | 56 +++++
 tb/tb_pline_flush_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pline_flush_unit.sv
// pline_flush_unit: per-stage bubble vector for an in-order pipeline with mispredict and exception flushes
module pline_flush_unit #(
    parameter int NUM_STAGES    = 4,
    parameter int RESOLVE_STAGE = 2,
    parameter int EXC_STAGE     = 3,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  incorrect_pred,
    input  logic                  exception,
    input  logic                  cnt_clr,
    output logic [NUM_STAGES-1:0] stage_ignore,
    output logic                  flushing,
    output logic                  flush_done,
    output logic [1:0]            flush_src,
    output logic [CNT_W-1:0]      flush_cnt
);
    if (NUM_STAGES < 2 || RESOLVE_STAGE >= NUM_STAGES || EXC_STAGE >= NUM_STAGES) begin : g_param_err
        $error("pline_flush_unit: stage parameters out of range");
    end

    localparam logic [NUM_STAGES-1:0] PRED_MASK = {NUM_STAGES{1'b1}} >> (NUM_STAGES - 1 - RESOLVE_STAGE);
    localparam logic [NUM_STAGES-1:0] EXC_MASK  = {NUM_STAGES{1'b1}} >> (NUM_STAGES - 1 - EXC_STAGE);

    logic [NUM_STAGES-1:0] req_mask;
    logic [NUM_STAGES-1:0] adv;
    logic [NUM_STAGES-1:0] nxt_ignore;
    logic                  req;

    // bubbles shift toward writeback unless stalled; new flush masks are ORed on top
    always_comb begin
        req        = incorrect_pred | exception;
        req_mask   = (incorrect_pred ? PRED_MASK : '0) | (exception ? EXC_MASK : '0);
        adv        = stall ? stage_ignore : {stage_ignore[NUM_STAGES-2:0], 1'b0};
        nxt_ignore = adv | req_mask;
    end

    // flush state, completion pulse, source tracking and saturating event counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_ignore <= '0;
            flush_done   <= 1'b0;
            flush_src    <= 2'b00;
            flush_cnt    <= '0;
        end else begin
            stage_ignore <= nxt_ignore;
            flush_done   <= (|stage_ignore) & ~(|nxt_ignore);
            flush_src    <= exception ? 2'b10 : incorrect_pred ? 2'b01 : flush_src;
            flush_cnt    <= cnt_clr ? '0 : (req && !(&flush_cnt)) ? flush_cnt + 1'b1 : flush_cnt;
        end
    end

    assign flushing = |stage_ignore;
endmodule

// File: tb/tb_pline_flush_unit.sv
// tb_pline_flush_unit: random and directed flush traffic scored against a stage-array model
module tb_pline_flush_unit;
    localparam int N = 4;
    localparam int R = 2;
    localparam int E = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0, incorrect_pred = 1'b0, exception = 1'b0, cnt_clr = 1'b0;
    logic [N-1:0] stage_ignore, ign2;
    logic flushing, flush_done, fl2, done2;
    logic [1:0] flush_src, src2;
    logic [15:0] flush_cnt;
    logic [1:0] cnt2;

    pline_flush_unit #(.NUM_STAGES(N), .RESOLVE_STAGE(R), .EXC_STAGE(E), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .incorrect_pred(incorrect_pred),
        .exception(exception), .cnt_clr(cnt_clr), .stage_ignore(stage_ignore),
        .flushing(flushing), .flush_done(flush_done), .flush_src(flush_src), .flush_cnt(flush_cnt)
    );

    pline_flush_unit #(.NUM_STAGES(N), .RESOLVE_STAGE(R), .EXC_STAGE(E), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .incorrect_pred(incorrect_pred),
        .exception(exception), .cnt_clr(cnt_clr), .stage_ignore(ign2),
        .flushing(fl2), .flush_done(done2), .flush_src(src2), .flush_cnt(cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] ign;
        logic         done;
        logic [1:0]   src;
        int           cnt;
        int           cnt_sat;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    bit m_bubble[N];
    int m_src = 0;
    int m_cnt = 0;
    int m_cnt_sat = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic bit any_bubble();
        bit a = 0;
        for (int i = 0; i < N; i++) a |= m_bubble[i];
        return a;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_bubble[i] = 0;
        m_src = 0;
        m_cnt = 0;
        m_cnt_sat = 0;
        q.delete();
    endtask

    task automatic cyc(input bit s, input bit p, input bit e, input bit c);
        exp_t x;
        bit was_busy;
        @(negedge clk);
        stall = s;
        incorrect_pred = p;
        exception = e;
        cnt_clr = c;
        was_busy = any_bubble();
        if (!s) begin
            for (int i = N - 1; i > 0; i--) m_bubble[i] = m_bubble[i-1];
            m_bubble[0] = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (p && i <= R) m_bubble[i] = 1;
            if (e && i <= E) m_bubble[i] = 1;
        end
        if (e) m_src = 2;
        else if (p) m_src = 1;
        if (c) begin
            m_cnt = 0;
            m_cnt_sat = 0;
        end else if (p || e) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_sat < 3) m_cnt_sat++;
        end
        for (int i = 0; i < N; i++) x.ign[i] = m_bubble[i];
        x.done = was_busy && !any_bubble();
        x.src = 2'(m_src);
        x.cnt = m_cnt;
        x.cnt_sat = m_cnt_sat;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ign"}, 32'(stage_ignore), 0);
        chk({tag, "_flushing"}, 32'(flushing), 0);
        chk({tag, "_done"}, 32'(flush_done), 0);
        chk({tag, "_src"}, 32'(flush_src), 0);
        chk({tag, "_cnt"}, 32'(flush_cnt), 0);
        chk({tag, "_cnt_sat"}, 32'(cnt2), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        stall = 0;
        incorrect_pred = 0;
        exception = 0;
        cnt_clr = 0;
        #1;
        check_zero("async_reset");
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // scoreboard monitor: one expected entry per clock edge after stimulus
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("stage_ignore", 32'(stage_ignore), 32'(x.ign));
                chk("flushing", 32'(flushing), 32'(|x.ign));
                chk("flush_done", 32'(flush_done), 32'(x.done));
                chk("flush_src", 32'(flush_src), 32'(x.src));
                chk("flush_cnt", 32'(flush_cnt), 32'(x.cnt));
                chk("flush_cnt_sat", 32'(cnt2), 32'(x.cnt_sat));
                chk("sat_ign", 32'(ign2), 32'(x.ign));
            end
        end
    end

    initial begin
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 0, 0); idle(6);
        cyc(0, 0, 1, 0); idle(6);
        cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); idle(6);
        cyc(0, 1, 0, 0); idle(1); cyc(0, 0, 1, 0); idle(6);
        cyc(0, 1, 1, 0); idle(6);
        cyc(0, 1, 0, 0); idle(1); do_reset();
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
        idle(5);
        cyc(0, 1, 0, 1); idle(5);
        cyc(1, 0, 1, 0); cyc(1, 1, 0, 0); cyc(0, 0, 0, 0); idle(6);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 400) == 0) do_reset();
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 13) == 0, $urandom_range(0, 40) == 0);
        end
        idle(6);
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
